disp_cont_mod16: RTL



---
 rtl/disp_cont_mod16.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/disp_cont_mod16.sv
// disp_cont_mod16
// Two-digit multiplexed 7-segment display for the mod-16 irrigation timer
// counter. Once per scan frame it captures the counter value and direction,
// splits the value into tens and units, and scans the two digits onto a
// shared segment bus. Each digit is preceded by a short blanking gap, and a
// leading zero in the tens place is suppressed.
//
// Parameters
//   SCAN_DIV   clock cycles each digit stays lit (1..65535)
//   BLINK_DIV  clock cycles per blink half-period (1..16777215)
//
// Ports
//   Clk             system clock, rising edge
//   Rst             synchronous active-high reset
//   Q3..Q0          counter state, Q3 is the MSB
//   Y               counter direction, 1 = counting up
//   Seg[6:0]        segments a..g, active-high, Seg[6] = a
//   Dp              decimal point, active-high, lit on units when counting up
//   An[1:0]         digit enables, active-low, An[0] = units, An[1] = tens
//
// Optional feature
//   DISP_BLINK_EN   when defined, a displayed value of 0 flashes with a
//                   half-period of BLINK_DIV cycles to signal timer expiry.
module disp_cont_mod16 #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Q3,
  input  logic       Q2,
  input  logic       Q1,
  input  logic       Q0,
  input  logic       Y,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [1:0] An
);

  typedef enum logic [1:0] {
    GAP1 = 2'd0,
    DIG0 = 2'd1,
    GAP0 = 2'd2,
    DIG1 = 2'd3
  } state_t;

  localparam logic [15:0] GAP_LAST  = 16'd1;
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic        state_done;
  logic [15:0] presc;
  logic [3:0]  val;
  logic        ydir;
  logic        tens;
  logic [3:0]  units;
  logic        blink_blank;

  // Next-state logic: the gap states always last two cycles, the digit
  // states last SCAN_DIV cycles. The prescaler counts cycles spent in the
  // current state, so each state ends when it reaches its last count.
  always_comb begin
    state_nxt  = state;
    state_done = 1'b0;
    case (state)
      GAP1: if (presc == GAP_LAST)  state_nxt = DIG0;
      DIG0: if (presc == SCAN_LAST) state_nxt = GAP0;
      GAP0: if (presc == GAP_LAST)  state_nxt = DIG1;
      DIG1: if (presc == SCAN_LAST) state_nxt = GAP1;
      default:                      state_nxt = GAP1;
    endcase
    state_done = (state_nxt != state);
  end

  // State register and prescaler. The prescaler restarts from zero on every
  // transition; reset drops any partly shown frame and restarts at GAP1.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= GAP1;
      presc <= 16'd0;
    end else begin
      state <= state_nxt;
      presc <= state_done ? 16'd0 : presc + 16'd1;
    end
  end

  // Counter capture. The value is only sampled while the display is blanked
  // in GAP1, so the last GAP1 edge decides what the whole frame shows and a
  // counter change mid-frame can never split the two digits.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      val  <= 4'd0;
      ydir <= 1'b0;
    end else if (state == GAP1) begin
      val  <= {Q3, Q2, Q1, Q0};
      ydir <= Y;
    end
  end

  assign tens  = (val >= 4'd10);
  assign units = tens ? (val - 4'd10) : val;

`ifdef DISP_BLINK_EN
  localparam logic [23:0] BLINK_LAST = 24'(BLINK_DIV - 1);

  logic [23:0] blink_cnt;
  logic        blink_on;

  // Free-running blink timebase; the phase flips every BLINK_DIV cycles and
  // starts in the lit phase after reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      blink_cnt <= 24'd0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= 24'd0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 24'd1;
    end
  end

  assign blink_blank = (val == 4'd0) && !blink_on;
`else
  // No blinking in this build. BLINK_DIV is always positive, so this is a
  // constant zero that merely keeps the parameter referenced.
  assign blink_blank = (BLINK_DIV < 0);
`endif

  function automatic logic [6:0] font(input logic [3:0] digit);
    case (digit)
      4'd0:    font = 7'h7E;
      4'd1:    font = 7'h30;
      4'd2:    font = 7'h6D;
      4'd3:    font = 7'h79;
      4'd4:    font = 7'h33;
      4'd5:    font = 7'h5B;
      4'd6:    font = 7'h5F;
      4'd7:    font = 7'h70;
      4'd8:    font = 7'h7F;
      4'd9:    font = 7'h7B;
      default: font = 7'h00;
    endcase
  endfunction

  // Moore output decode from registered state only. Gaps are dark, the
  // tens digit is dark when it would be a leading zero, and an expired
  // timer (value 0) may be blanked entirely by the blink phase.
  always_comb begin
    An  = 2'b11;
    Seg = 7'h00;
    Dp  = 1'b0;
    if (!blink_blank) begin
      case (state)
        DIG0: begin
          An  = 2'b10;
          Seg = font(units);
          Dp  = ydir;
        end
        DIG1: begin
          if (tens) begin
            An  = 2'b01;
            Seg = font(4'd1);
          end
        end
        default: begin
          An  = 2'b11;
          Seg = 7'h00;
          Dp  = 1'b0;
        end
      endcase
    end
  end

endmodule
